// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
//   Bridges the memory-stage data request (word address, store data, byte
//   mask, read/write enables) onto a variable-latency valid/ready data bus.
//   Each request is registered, the bus handshake is run, and the pipeline is
//   stalled until the access completes. Raw 32-bit read data is returned for
//   the load-extension logic; bus errors are reported as a one-cycle fault.
//
//   Optional build macro: BUS_TIMEOUT_EN
//     defined   : an access that spends TIMEOUT_CYCLES cycles in REQ/WAIT_RD
//                 is aborted and completes with a fault.
//     undefined : the bridge waits indefinitely for the bus.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req_addr/wdata/mask/ren/wen   request from the memory stage
//   o_req_rdata         read data, valid in the DONE cycle of a read
//   o_stall             pipeline freeze
//   o_bus_fault         one-cycle pulse in DONE when the access failed
//   o_bus_valid/addr/wdata/mask/we, i_bus_ready    bus request channel
//   i_bus_rvalid/rdata/err                         bus response channel
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; latches it when ren or wen is high
// REQ   | bus request presented, held stable until i_bus_ready
// WAIT_RD | read accepted, waiting for i_bus_rvalid
// DONE  | one-cycle completion: rdata/fault presented, stall released
// -----------------------------------------------------------------------------
module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  output logic [31:0] o_req_rdata,
  output logic        o_stall,
  output logic        o_bus_fault,
  output logic        o_bus_valid,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_mask,
  output logic        o_bus_we,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // The counter must be able to hold TIMEOUT_CYCLES.
  if (TIMEOUT_W < 1 || TIMEOUT_W > 30 || TIMEOUT_CYCLES < 1 ||
      TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_cfg
    $error("dmem_bridge: TIMEOUT_W too narrow for TIMEOUT_CYCLES");
  end

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic        r_we;
  logic [31:0] r_rdata;
  logic        r_fault;

  logic w_idle;
  logic w_req;
  logic w_wait_rd;
  logic w_done;
  logic w_req_any;
  logic w_timeout;

  assign w_idle    = (r_state == S_IDLE);
  assign w_req     = (r_state == S_REQ);
  assign w_wait_rd = (r_state == S_WAIT_RD);
  assign w_done    = (r_state == S_DONE);
  assign w_req_any = i_req_ren | i_req_wen;

`ifdef BUS_TIMEOUT_EN
  // The compare fires in the cycle the count would reach TIMEOUT_CYCLES, so
  // exactly TIMEOUT_CYCLES cycles are spent in REQ + WAIT_RD before DONE.
  localparam logic [TIMEOUT_W-1:0] LP_TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] r_to_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
    end else if (w_idle) begin
      // REQ is only entered from IDLE, so clearing here clears on entry.
      r_to_cnt <= '0;
    end else if (w_req || w_wait_rd) begin
      r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
    end
  end

  assign w_timeout = (w_req || w_wait_rd) && (r_to_cnt == LP_TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_mask  <= i_req_mask;
            r_we    <= i_req_wen;  // write wins when both enables are high
            r_rdata <= '0;
            r_fault <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // Acceptance takes priority over a timeout in the same cycle.
          if (i_bus_ready) begin
            if (r_we) begin
              r_fault <= i_bus_err;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT_RD;
            end
          end else if (w_timeout) begin
            r_fault <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_WAIT_RD: begin
          if (i_bus_rvalid) begin
            // Faulted reads return zero rather than whatever the bus drove.
            r_rdata <= i_bus_err ? 32'h0 : i_bus_rdata;
            r_fault <= i_bus_err;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_fault <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Reset gates the combinational stall so the pipeline is not frozen while
  // the bridge is held in reset with a request pending.
  assign o_stall     = i_rst_n & ((w_idle & w_req_any) | w_req | w_wait_rd);
  assign o_bus_valid = w_req;
  assign o_bus_addr  = r_addr;
  assign o_bus_wdata = r_wdata;
  assign o_bus_mask  = r_mask;
  assign o_bus_we    = r_we;
  assign o_req_rdata = w_done ? r_rdata : 32'h0;
  assign o_bus_fault = w_done & r_fault;

endmodule
